// File: rtl/inst_sram_responder.sv
// Responder for the req/addr_ok/data_ok instruction-fetch bus: in-window requests go to a
// variable-latency backend, out-of-window ones are answered locally, all responses in order.
module inst_sram_responder #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] WIN_BASE = 32'h1c00_0000,
    parameter logic [31:0] WIN_MASK = 32'hfff0_0000,
    parameter logic [31:0] ERR_DATA = 32'hdead_beef
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inst_sram_req,
    input  logic                      inst_sram_wr,
    input  logic [1:0]                inst_sram_size,
    input  logic [3:0]                inst_sram_wstrb,
    input  logic [31:0]               inst_sram_addr,
    input  logic [31:0]               inst_sram_wdata,
    output logic                      inst_sram_addr_ok,
    output logic                      inst_sram_data_ok,
    output logic [31:0]               inst_sram_rdata,
    output logic                      mem_req,
    output logic                      mem_wr,
    output logic [1:0]                mem_size,
    output logic [3:0]                mem_wstrb,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic                      mem_gnt,
    input  logic                      mem_rvalid,
    input  logic [31:0]               mem_rdata,
    output logic [$clog2(DEPTH):0]    outstanding,
    output logic                      proto_err
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    // Order FIFO: one entry per accepted request, popped on data_ok emission.
    logic             r_ord_local [DEPTH];
    logic             r_ord_wr    [DEPTH];
    logic [AW-1:0]    r_ord_wptr;
    logic [AW-1:0]    r_ord_rptr;

    // Backend slot ring: slots between r_rsp_rptr and r_be_wptr are live backend requests;
    // r_rsp_wptr splits them into answered (below) and still pending (above).
    logic             r_slot_wr   [DEPTH];
    logic [31:0]      r_slot_data [DEPTH];
    logic [AW:0]      r_be_wptr;
    logic [AW:0]      r_rsp_wptr;
    logic [AW:0]      r_rsp_rptr;

    logic [AW:0]      r_outstanding;
    logic             r_data_ok;
    logic [31:0]      r_rdata;
    logic             r_proto_err;

    logic             w_inwin;
    logic             w_full;
    logic             w_accept;
    logic             w_be_acc;
    logic [AW:0]      w_be_pend;
    logic             w_rsp_push;
    logic             w_rsp_avail;
    logic             w_head_local;
    logic             w_head_wr;
    logic             w_emit;
    logic [31:0]      w_emit_data;

    assign w_inwin  = (inst_sram_addr & WIN_MASK) == WIN_BASE;
    assign w_full   = (r_outstanding == FULL_CNT);

    assign mem_req           = inst_sram_req & w_inwin & ~w_full & ~rst;
    assign inst_sram_addr_ok = inst_sram_req & ~w_full & ~rst & (w_inwin ? mem_gnt : 1'b1);
    assign w_accept          = inst_sram_addr_ok;
    assign w_be_acc          = mem_req & mem_gnt;

    assign mem_wr    = inst_sram_wr;
    assign mem_size  = inst_sram_size;
    assign mem_wstrb = inst_sram_wstrb;
    assign mem_addr  = inst_sram_addr;
    assign mem_wdata = inst_sram_wdata;

    assign w_be_pend   = r_be_wptr - r_rsp_wptr;
    assign w_rsp_push  = mem_rvalid & (w_be_pend != '0);
    assign w_rsp_avail = (r_rsp_wptr != r_rsp_rptr);

    assign w_head_local = r_ord_local[r_ord_rptr];
    assign w_head_wr    = r_ord_wr[r_ord_rptr];
    assign w_emit       = (r_outstanding != '0) & (w_head_local | w_rsp_avail);
    assign w_emit_data  = w_head_local ? (w_head_wr ? 32'h0 : ERR_DATA)
                                       : r_slot_data[r_rsp_rptr[AW-1:0]];

    // Storage needs no reset: every entry is written before its pointer makes it visible.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_ord_local[r_ord_wptr] <= ~w_inwin;
            r_ord_wr[r_ord_wptr]    <= inst_sram_wr;
        end
        if (w_be_acc) begin
            r_slot_wr[r_be_wptr[AW-1:0]] <= inst_sram_wr;
        end
        if (w_rsp_push) begin
            r_slot_data[r_rsp_wptr[AW-1:0]] <= r_slot_wr[r_rsp_wptr[AW-1:0]] ? 32'h0 : mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ord_wptr    <= '0;
            r_ord_rptr    <= '0;
            r_be_wptr     <= '0;
            r_rsp_wptr    <= '0;
            r_rsp_rptr    <= '0;
            r_outstanding <= '0;
            r_data_ok     <= 1'b0;
            r_rdata       <= 32'h0;
            r_proto_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ord_wptr <= r_ord_wptr + 1'b1;
            end
            if (w_be_acc) begin
                r_be_wptr <= r_be_wptr + 1'b1;
            end
            if (w_rsp_push) begin
                r_rsp_wptr <= r_rsp_wptr + 1'b1;
            end
            if (mem_rvalid && (w_be_pend == '0)) begin
                r_proto_err <= 1'b1;
            end

            r_data_ok <= w_emit;
            if (w_emit) begin
                r_rdata    <= w_emit_data;
                r_ord_rptr <= r_ord_rptr + 1'b1;
                if (!w_head_local) begin
                    r_rsp_rptr <= r_rsp_rptr + 1'b1;
                end
            end

            unique case ({w_accept, w_emit})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign inst_sram_data_ok = r_data_ok & ~rst;
    assign inst_sram_rdata   = r_rdata;
    assign outstanding       = r_outstanding;
    assign proto_err         = r_proto_err;
endmodule

// File: tb/tb_inst_sram_responder.sv
// Bench for inst_sram_responder: directed scenarios with fixed expectations, then random
// traffic checked against a queue-based model of in-order, one-per-cycle responses.
module tb_inst_sram_responder;
    localparam int          DEPTH = 4;
    localparam logic [31:0] WB    = 32'h1c00_0000;
    localparam logic [31:0] WM    = 32'hfff0_0000;
    localparam logic [31:0] ED    = 32'hdead_beef;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_sram_req = 1'b0;
    logic        inst_sram_wr = 1'b0;
    logic [1:0]  inst_sram_size = 2'd2;
    logic [3:0]  inst_sram_wstrb = 4'h0;
    logic [31:0] inst_sram_addr = 32'h0;
    logic [31:0] inst_sram_wdata = 32'h0;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [2:0]  outstanding;
    logic        proto_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inst_sram_responder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .outstanding(outstanding), .proto_err(proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive just after the rising edge, return at the falling edge for checks.
    task automatic drv(input logic r, input logic rq, input logic w, input logic [31:0] a,
                       input logic g, input logic rv, input logic [31:0] rd);
        @(posedge clk);
        #1;
        rst             = r;
        inst_sram_req   = rq;
        inst_sram_wr    = w;
        inst_sram_size  = 2'd2;
        inst_sram_wstrb = w ? 4'hf : 4'h0;
        inst_sram_addr  = a;
        inst_sram_wdata = a ^ 32'h5a5a_0f0f;
        mem_gnt         = g;
        mem_rvalid      = rv;
        mem_rdata       = rd;
        @(negedge clk);
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    typedef struct {
        bit          loc;
        bit          wr;
        bit          known;
        logic [31:0] val;
        int          avail;
    } rec_t;

    initial begin
        rec_t        rq[$];
        rec_t        t;
        int          last_emit;
        int          pend;
        bit          found;
        bit          e_dok, e_mreq, e_aok, inwin, full, exp_perr;
        logic [31:0] exp_rdata;
        logic [31:0] a, rd;
        bit          req, wr, g, rv;

        // Reset state, with an in-window granted request present to show gating.
        drv(1'b1, 1'b1, 1'b0, WB, 1'b1, 1'b0, 32'h0);
        chk("rst_addr_ok", inst_sram_addr_ok, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_data_ok", inst_sram_data_ok, 0);
        chk("rst_rdata", inst_sram_rdata, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_proto_err", proto_err, 0);

        // Single in-window read: rvalid at T+3 -> data_ok at T+5.
        drv(0, 1, 0, 32'h1c00_0000, 1, 0, 0);
        chk("rd_addr_ok", inst_sram_addr_ok, 1);
        chk("rd_mem_req", mem_req, 1);
        chk("rd_mem_addr", mem_addr, 32'h1c00_0000);
        idle();
        idle();
        drv(0, 0, 0, 0, 0, 1, 32'h0280_0000);
        chk("rd_no_early_dok", inst_sram_data_ok, 0);
        idle();
        chk("rd_dok_t4", inst_sram_data_ok, 0);
        chk("rd_out_t4", outstanding, 1);
        idle();
        chk("rd_dok_t5", inst_sram_data_ok, 1);
        chk("rd_rdata_t5", inst_sram_rdata, 32'h0280_0000);
        chk("rd_out_t5", outstanding, 0);
        idle();
        chk("rd_dok_t6", inst_sram_data_ok, 0);
        chk("rd_rdata_hold", inst_sram_rdata, 32'h0280_0000);

        // Out-of-window read answered locally, no backend grant needed.
        drv(0, 1, 0, 32'h1bff_fffc, 0, 0, 0);
        chk("loc_mem_req", mem_req, 0);
        chk("loc_addr_ok", inst_sram_addr_ok, 1);
        idle();
        chk("loc_dok_t1", inst_sram_data_ok, 0);
        chk("loc_out_t1", outstanding, 1);
        idle();
        chk("loc_dok_t2", inst_sram_data_ok, 1);
        chk("loc_rdata_t2", inst_sram_rdata, ED);

        // Ordering: local read behind a slow backend read.
        drv(0, 1, 0, 32'h1c00_0040, 1, 0, 0);
        chk("ord_a_addr_ok", inst_sram_addr_ok, 1);
        drv(0, 1, 0, 32'h0000_1000, 0, 0, 0);
        chk("ord_b_addr_ok", inst_sram_addr_ok, 1);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("ord_wait_dok", inst_sram_data_ok, 0);
        end
        drv(0, 0, 0, 0, 0, 1, 32'h1111_2222);
        idle();
        chk("ord_dok_t7", inst_sram_data_ok, 0);
        idle();
        chk("ord_a_dok", inst_sram_data_ok, 1);
        chk("ord_a_rdata", inst_sram_rdata, 32'h1111_2222);
        idle();
        chk("ord_b_dok", inst_sram_data_ok, 1);
        chk("ord_b_rdata", inst_sram_rdata, ED);
        idle();
        chk("ord_done_dok", inst_sram_data_ok, 0);
        chk("ord_done_out", outstanding, 0);

        // Full: four backend reads, then a local request stalls until an emission.
        for (int i = 0; i < 4; i++) begin
            drv(0, 1, 0, 32'h1c00_0100 + 32'(4 * i), 1, 0, 0);
            chk("full_fill_aok", inst_sram_addr_ok, 1);
        end
        drv(0, 1, 0, 32'h0000_2000, 1, 0, 0);
        chk("full_out", outstanding, 4);
        chk("full_aok", inst_sram_addr_ok, 0);
        drv(0, 1, 0, 32'h0000_2000, 1, 1, 32'h0000_00a0);
        chk("full_aok_rv", inst_sram_addr_ok, 0);
        drv(0, 1, 0, 32'h0000_2000, 1, 0, 0);
        chk("full_aok_wait", inst_sram_addr_ok, 0);
        chk("full_dok_wait", inst_sram_data_ok, 0);
        drv(0, 1, 0, 32'h0000_2000, 1, 0, 0);
        chk("full_dok", inst_sram_data_ok, 1);
        chk("full_rdata0", inst_sram_rdata, 32'h0000_00a0);
        chk("full_out_after", outstanding, 3);
        chk("full_aok_reassert", inst_sram_addr_ok, 1);
        drv(0, 0, 0, 0, 0, 1, 32'h0000_00b1);
        chk("full_out_refill", outstanding, 4);
        drv(0, 0, 0, 0, 0, 1, 32'h0000_00b2);
        drv(0, 0, 0, 0, 0, 1, 32'h0000_00b3);
        chk("full_rdata1", inst_sram_rdata, 32'h0000_00b1);
        idle();
        chk("full_rdata2", inst_sram_rdata, 32'h0000_00b2);
        idle();
        chk("full_rdata3", inst_sram_rdata, 32'h0000_00b3);
        idle();
        chk("full_local_dok", inst_sram_data_ok, 1);
        chk("full_local_rdata", inst_sram_rdata, ED);
        idle();
        chk("full_drained", outstanding, 0);

        // Backpressured in-window write, then write response forced to zero.
        for (int i = 0; i < 3; i++) begin
            drv(0, 1, 1, 32'h1c00_0200, 0, 0, 0);
            chk("bp_aok", inst_sram_addr_ok, 0);
            chk("bp_mem_req", mem_req, 1);
            chk("bp_out", outstanding, 0);
        end
        chk("bp_mem_wr", mem_wr, 1);
        chk("bp_mem_wstrb", mem_wstrb, 4'hf);
        chk("bp_mem_wdata", mem_wdata, 32'h1c00_0200 ^ 32'h5a5a_0f0f);
        drv(0, 1, 1, 32'h1c00_0200, 1, 0, 0);
        chk("bp_grant_aok", inst_sram_addr_ok, 1);
        drv(0, 0, 0, 0, 0, 1, 32'hffff_ffff);
        chk("wr_out", outstanding, 1);
        idle();
        idle();
        chk("wr_dok", inst_sram_data_ok, 1);
        chk("wr_rdata", inst_sram_rdata, 0);
        idle();
        chk("wr_out_done", outstanding, 0);

        // Stray rvalid, then reset with two requests in flight.
        drv(0, 0, 0, 0, 0, 1, 32'h5555_5555);
        chk("perr_before", proto_err, 0);
        idle();
        chk("perr_set", proto_err, 1);
        chk("perr_no_dok", inst_sram_data_ok, 0);
        idle();
        chk("perr_no_dok2", inst_sram_data_ok, 0);
        chk("perr_out", outstanding, 0);
        drv(0, 1, 0, 32'h1c00_0300, 1, 0, 0);
        drv(0, 1, 0, 32'h0000_3000, 0, 0, 0);
        drv(1, 1, 0, WB, 1, 0, 0);
        chk("mrst_out_before", outstanding, 2);
        chk("mrst_aok", inst_sram_addr_ok, 0);
        chk("mrst_mem_req", mem_req, 0);
        idle();
        chk("mrst_out", outstanding, 0);
        chk("mrst_dok", inst_sram_data_ok, 0);
        chk("mrst_perr", proto_err, 0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("mrst_quiet", inst_sram_data_ok, 0);
        end

        // Random traffic against the in-order response model.
        last_emit = -10;
        exp_rdata = inst_sram_rdata === 32'h0 ? 32'h0 : 32'h0;
        exp_perr  = 0;
        for (int c = 0; c < 400; c++) begin
            req = ($urandom_range(0, 9) < 6);
            a   = ($urandom_range(0, 9) < 6) ? (WB | ($urandom & ~WM)) : $urandom;
            wr  = ($urandom_range(0, 3) == 0);
            g   = ($urandom_range(0, 9) < 7);
            pend = 0;
            foreach (rq[i]) if (!rq[i].loc && !rq[i].known) pend++;
            rv  = (pend > 0) && ($urandom_range(0, 9) < 4);
            rd  = $urandom;
            drv(0, req, wr, a, g, rv, rd);

            e_dok = 0;
            if (rq.size() > 0 && rq[0].known && rq[0].avail <= c && last_emit + 1 <= c) begin
                e_dok     = 1;
                exp_rdata = rq[0].val;
                void'(rq.pop_front());
                last_emit = c;
            end
            full   = (rq.size() == DEPTH);
            inwin  = ((a & WM) == WB);
            e_mreq = req && inwin && !full;
            e_aok  = req && !full && (inwin ? g : 1'b1);

            chk("r_addr_ok", inst_sram_addr_ok, e_aok);
            chk("r_mem_req", mem_req, e_mreq);
            chk("r_mem_addr", mem_addr, a);
            chk("r_data_ok", inst_sram_data_ok, e_dok);
            chk("r_rdata", inst_sram_rdata, exp_rdata);
            chk("r_outstanding", outstanding, rq.size());
            chk("r_proto_err", proto_err, exp_perr);

            if (rv) begin
                found = 0;
                foreach (rq[i]) begin
                    if (!found && !rq[i].loc && !rq[i].known) begin
                        rq[i].known = 1;
                        rq[i].val   = rq[i].wr ? 32'h0 : rd;
                        rq[i].avail = c + 2;
                        found       = 1;
                    end
                end
                if (!found) exp_perr = 1;
            end
            if (e_aok) begin
                t.loc   = !inwin;
                t.wr    = wr;
                t.known = !inwin;
                t.val   = wr ? 32'h0 : ED;
                t.avail = c + 2;
                rq.push_back(t);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
